// File: rtl/seg7_pkg.sv
// Shared glyph patterns, symbol codes, error encodings and monitor states for the
// seven-segment scroll monitor.
package seg7_pkg;

  // Segment vectors are {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
  localparam logic [6:0] GLYPH_D     = 7'b0100001;
  localparam logic [6:0] GLYPH_E     = 7'b0000110;
  localparam logic [6:0] GLYPH_ZERO  = 7'b1000000;

  localparam logic [1:0] SYM_BLANK = 2'd0;
  localparam logic [1:0] SYM_D     = 2'd1;
  localparam logic [1:0] SYM_E     = 2'd2;
  localparam logic [1:0] SYM_ZERO  = 2'd3;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'b00,
    ERR_GLYPH  = 2'b01,
    ERR_ORDER  = 2'b10,
    ERR_PERIOD = 2'b11
  } err_kind_e;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2,
    FAULT  = 2'd3
  } state_e;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Maps one active-low seven-segment pattern back to its 2-bit message symbol.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [1:0] code,
  output logic       valid
);

  always_comb begin
    code  = SYM_BLANK;
    valid = 1'b1;
    case (seg)
      GLYPH_BLANK: code = SYM_BLANK;
      GLYPH_D:     code = SYM_D;
      GLYPH_E:     code = SYM_E;
      GLYPH_ZERO:  code = SYM_ZERO;
      default:     valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scroll_monitor.sv
// Scroll-order checker for the four-digit "dE0" display; locks onto the ring phase
// and flags glyph, order and (with SEG7_SCROLL_PERIOD_CHECK_EN) step-period faults.
module seg7_scroll_monitor
  import seg7_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = 2,
  parameter int unsigned EXP_PERIOD = 50000000,
  parameter int unsigned PERIOD_TOL = 1000,
  parameter int unsigned PERIOD_W   = 27
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic [6:0]          hex0,
  input  logic [6:0]          hex1,
  input  logic [6:0]          hex2,
  input  logic [6:0]          hex3,
  input  logic                clr_err,
  output logic                locked,
  output logic [1:0]          phase,
  output logic                step,
  output logic [15:0]         step_cnt,
  output logic                err,
  output logic [1:0]          err_kind,
  output logic [PERIOD_W-1:0] last_period
);

  logic [27:0] s1_q, s2_q;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      s1_q <= '1;
      s2_q <= '1;
    end else begin
      s1_q <= {hex3, hex2, hex1, hex0};
      s2_q <= s1_q;
    end
  end

  logic [1:0] c3, c2, c1, c0;
  logic [3:0] vld;

  seg7_glyph_decode u_dec3 (.seg(s1_q[27:21]), .code(c3), .valid(vld[3]));
  seg7_glyph_decode u_dec2 (.seg(s1_q[20:14]), .code(c2), .valid(vld[2]));
  seg7_glyph_decode u_dec1 (.seg(s1_q[13:7]),  .code(c1), .valid(vld[1]));
  seg7_glyph_decode u_dec0 (.seg(s1_q[6:0]),   .code(c0), .valid(vld[0]));

  logic glyph_ok, win_ok;

  // The ring is 0,1,2,3, so a valid window is hex3's symbol followed by +1,+2,+3.
  assign glyph_ok = &vld;
  assign win_ok   = glyph_ok
                 && (c2 == 2'(c3 + 2'd1))
                 && (c1 == 2'(c3 + 2'd2))
                 && (c0 == 2'(c3 + 2'd3));

  logic       ev_change, ev_glyph_ok, ev_win_ok;
  logic [1:0] ev_phase;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      ev_change   <= 1'b0;
      ev_glyph_ok <= 1'b0;
      ev_win_ok   <= 1'b0;
      ev_phase    <= '0;
    end else begin
      ev_change   <= (s1_q != s2_q);
      ev_glyph_ok <= glyph_ok;
      ev_win_ok   <= win_ok;
      ev_phase    <= c3;
    end
  end

  logic period_ok;

`ifdef SEG7_SCROLL_PERIOD_CHECK_EN
  localparam logic [PERIOD_W-1:0] P1_LO = PERIOD_W'(EXP_PERIOD - PERIOD_TOL);
  localparam logic [PERIOD_W-1:0] P1_HI = PERIOD_W'(EXP_PERIOD + PERIOD_TOL);
  localparam logic [PERIOD_W-1:0] P2_LO = PERIOD_W'(2 * EXP_PERIOD - PERIOD_TOL);
  localparam logic [PERIOD_W-1:0] P2_HI = PERIOD_W'(2 * EXP_PERIOD + PERIOD_TOL);

  logic [PERIOD_W-1:0] per_cnt_q, last_per_q;

  // per_cnt_q holds the cycles elapsed since the previous change event.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      per_cnt_q  <= '0;
      last_per_q <= '0;
    end else if (ev_change) begin
      per_cnt_q  <= PERIOD_W'(1);
      last_per_q <= per_cnt_q;
    end else if (per_cnt_q != '1) begin
      per_cnt_q  <= per_cnt_q + 1'b1;
    end
  end

  assign period_ok   = ((per_cnt_q >= P1_LO) && (per_cnt_q <= P1_HI))
                    || ((per_cnt_q >= P2_LO) && (per_cnt_q <= P2_HI));
  assign last_period = last_per_q;
`else
  // Period limits stay referenced so the unchecked build keeps the same parameter set.
  assign period_ok   = 1'b1 | (EXP_PERIOD[0] ^ PERIOD_TOL[0]);
  assign last_period = '0;
`endif

  state_e     state_q, state_d;
  logic [1:0] phase_q, phase_d, phase_next;
  logic [3:0] match_q, match_d, match_inc;
  logic       step_q, step_d;
  logic       locked_q;
  logic [15:0] step_cnt_q;
  logic       err_q, err_new;
  err_kind_e  err_kind_q, kind_new;

  assign phase_next = phase_q + 2'd1;
  assign match_inc  = match_q + 4'd1;

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    match_d  = match_q;
    step_d   = 1'b0;
    err_new  = 1'b0;
    kind_new = ERR_NONE;
    unique case (state_q)
      SEARCH: begin
        if (ev_win_ok) begin
          state_d = TRACK;
          phase_d = ev_phase;
          match_d = '0;
        end
      end
      TRACK: begin
        if (ev_change) begin
          if (ev_win_ok && (ev_phase == phase_next)) begin
            phase_d = ev_phase;
            match_d = match_inc;
            if (32'(match_inc) >= LOCK_COUNT) state_d = LOCKED;
          end else begin
            state_d = SEARCH;
            if (ev_win_ok) phase_d = ev_phase;
          end
        end
      end
      LOCKED: begin
        if (ev_change) begin
          if (!ev_glyph_ok) begin
            state_d  = FAULT;
            err_new  = 1'b1;
            kind_new = ERR_GLYPH;
          end else if (!ev_win_ok || (ev_phase != phase_next)) begin
            state_d  = FAULT;
            err_new  = 1'b1;
            kind_new = ERR_ORDER;
          end else if (!period_ok) begin
            state_d  = FAULT;
            err_new  = 1'b1;
            kind_new = ERR_PERIOD;
          end else begin
            phase_d = ev_phase;
            step_d  = 1'b1;
          end
        end
      end
      FAULT: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q    <= SEARCH;
      phase_q    <= '0;
      match_q    <= '0;
      step_q     <= 1'b0;
      locked_q   <= 1'b0;
      step_cnt_q <= '0;
      err_q      <= 1'b0;
      err_kind_q <= ERR_NONE;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      match_q  <= match_d;
      step_q   <= step_d;
      locked_q <= (state_d == LOCKED);
      if (step_d) step_cnt_q <= step_cnt_q + 16'd1;
      // A fresh fault outranks a simultaneous clear.
      if (err_new) begin
        err_q      <= 1'b1;
        err_kind_q <= kind_new;
      end else if (clr_err) begin
        err_q      <= 1'b0;
        err_kind_q <= ERR_NONE;
      end
    end
  end

  assign locked   = locked_q;
  assign phase    = phase_q;
  assign step     = step_q;
  assign step_cnt = step_cnt_q;
  assign err      = err_q;
  assign err_kind = err_kind_q;

endmodule

// File: tb/tb_seg7_scroll_monitor.sv
// Directed bench for seg7_scroll_monitor; period checks run when
// SEG7_SCROLL_PERIOD_CHECK_EN is defined.
module tb_seg7_scroll_monitor;

  logic        CLOCK_50 = 1'b0;
  logic        resetn;
  logic [6:0]  hex0, hex1, hex2, hex3;
  logic        clr_err;
  logic        locked;
  logic [1:0]  phase;
  logic        step;
  logic [15:0] step_cnt;
  logic        err;
  logic [1:0]  err_kind;
  logic [26:0] last_period;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  // Index = symbol: blank, 'd', 'E', '0'; vectors are {g..a}, active-low.
  logic [6:0] glyph [4] = '{7'b1111111, 7'b0100001, 7'b0000110, 7'b1000000};

  seg7_scroll_monitor #(
    .LOCK_COUNT(2),
    .EXP_PERIOD(100),
    .PERIOD_TOL(2),
    .PERIOD_W  (27)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .resetn     (resetn),
    .hex0       (hex0),
    .hex1       (hex1),
    .hex2       (hex2),
    .hex3       (hex3),
    .clr_err    (clr_err),
    .locked     (locked),
    .phase      (phase),
    .step       (step),
    .step_cnt   (step_cnt),
    .err        (err),
    .err_kind   (err_kind),
    .last_period(last_period)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic set_win(input logic [1:0] p);
    hex3 = glyph[p];
    hex2 = glyph[2'(p + 2'd1)];
    hex1 = glyph[2'(p + 2'd2)];
    hex0 = glyph[2'(p + 2'd3)];
  endtask

  // Accepted locked step, 100 cycles to the next window change.
  task automatic locked_step(input logic [1:0] p);
    set_win(p);
    cyc(3);
    exp_cnt++;
    check("step_hi", 32'(step), 32'd1);
    check("step_cnt", 32'(step_cnt), 32'(exp_cnt));
    check("step_phase", 32'(phase), 32'(p));
    cyc(1);
    check("step_lo", 32'(step), 32'd0);
    cyc(96);
  endtask

  initial begin
    resetn  = 1'b0;
    clr_err = 1'b0;
    hex0 = 7'h7f; hex1 = 7'h7f; hex2 = 7'h7f; hex3 = 7'h7f;
    cyc(2);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_step", 32'(step), 32'd0);
    check("rst_step_cnt", 32'(step_cnt), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_kind", 32'(err_kind), 32'd0);
    check("rst_last_period", 32'(last_period), 32'd0);

    resetn = 1'b1;
    set_win(2'd0);
    cyc(3);
    check("acq_locked", 32'(locked), 32'd0);
    check("acq_phase", 32'(phase), 32'd0);
    check("acq_err", 32'(err), 32'd0);
    cyc(97);
    set_win(2'd1);
    cyc(3);
    check("trk1_locked", 32'(locked), 32'd0);
    check("trk1_phase", 32'(phase), 32'd1);
    cyc(97);
    set_win(2'd2);
    cyc(3);
    check("lock_locked", 32'(locked), 32'd1);
    check("lock_phase", 32'(phase), 32'd2);
    check("lock_step", 32'(step), 32'd0);
    check("lock_step_cnt", 32'(step_cnt), 32'd0);
    cyc(97);
    locked_step(2'd3);
    locked_step(2'd0);
    locked_step(2'd1);
`ifndef SEG7_SCROLL_PERIOD_CHECK_EN
    check("no_period_tie", 32'(last_period), 32'd0);
`endif

    // Jump from phase 1 to phase 3.
    set_win(2'd3);
    cyc(3);
    check("ooo_err", 32'(err), 32'd1);
    check("ooo_kind", 32'(err_kind), 32'd2);
    check("ooo_locked", 32'(locked), 32'd0);
    cyc(97);
    set_win(2'd0);
    cyc(3);
    check("relock1_locked", 32'(locked), 32'd0);
    check("relock1_phase", 32'(phase), 32'd0);
    cyc(97);
    set_win(2'd1);
    cyc(3);
    check("relock2_locked", 32'(locked), 32'd1);
    check("relock2_phase", 32'(phase), 32'd1);
    check("sticky_err", 32'(err), 32'd1);
    clr_err = 1'b1;
    cyc(1);
    clr_err = 1'b0;
    check("clr_err", 32'(err), 32'd0);
    check("clr_kind", 32'(err_kind), 32'd0);
    cyc(96);

    hex1 = 7'b0000000;
    cyc(3);
    check("glyph_err", 32'(err), 32'd1);
    check("glyph_kind", 32'(err_kind), 32'd1);
    check("glyph_locked", 32'(locked), 32'd0);
    cyc(97);

    set_win(2'd0);
    cyc(100);
    set_win(2'd1);
    cyc(100);
    set_win(2'd2);
    cyc(3);
    check("relock3_locked", 32'(locked), 32'd1);
    check("relock3_phase", 32'(phase), 32'd2);

`ifdef SEG7_SCROLL_PERIOD_CHECK_EN
    cyc(197);
    set_win(2'd3);
    cyc(3);
    exp_cnt++;
    check("hold200_step", 32'(step), 32'd1);
    check("hold200_step_cnt", 32'(step_cnt), 32'(exp_cnt));
    check("hold200_last_period", 32'(last_period), 32'd200);
    cyc(94);
    set_win(2'd0);
    cyc(3);
    check("short_err", 32'(err), 32'd1);
    check("short_kind", 32'(err_kind), 32'd3);
    check("short_locked", 32'(locked), 32'd0);
    check("short_last_period", 32'(last_period), 32'd97);
    cyc(97);
    set_win(2'd1);
    cyc(100);
    set_win(2'd2);
    cyc(3);
    check("relock4_locked", 32'(locked), 32'd1);
`endif
    cyc(97);

    clr_err = 1'b1;
    cyc(1);
    clr_err = 1'b0;
    check("clr2_err", 32'(err), 32'd0);
    // Wrong successor (0 after 2) with clr_err on the same edge that records the fault.
    set_win(2'd0);
    cyc(2);
    clr_err = 1'b1;
    cyc(1);
    clr_err = 1'b0;
    check("clr_vs_new_err", 32'(err), 32'd1);
    check("clr_vs_new_kind", 32'(err_kind), 32'd2);
    check("clr_vs_new_locked", 32'(locked), 32'd0);
    cyc(97);

    set_win(2'd1);
    cyc(100);
    set_win(2'd2);
    cyc(3);
    check("relock5_locked", 32'(locked), 32'd1);
    check("pre_rst_step_cnt", 32'(step_cnt), 32'(exp_cnt));
    cyc(2);
    resetn = 1'b0;
    #2;
    check("async_locked", 32'(locked), 32'd0);
    check("async_phase", 32'(phase), 32'd0);
    check("async_step", 32'(step), 32'd0);
    check("async_step_cnt", 32'(step_cnt), 32'd0);
    check("async_err", 32'(err), 32'd0);
    check("async_kind", 32'(err_kind), 32'd0);
    check("async_last_period", 32'(last_period), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
